// File: rtl/irq_controller_vec_if.sv
// Request/trap bundle between peripherals, the core and irq_controller_vec.
// slave = controller side, master = core/peripheral side.
interface irq_controller_vec_if #(
  parameter int IRQ_NUM = 16
);
  logic               exception_i;
  logic               mret_i;
  logic [IRQ_NUM-1:0] irq_req_i;
  logic [IRQ_NUM-1:0] mie_i;
  logic               irq_o;
  logic [31:0]        irq_cause_o;
  logic [IRQ_NUM-1:0] irq_ret_o;
  logic               busy_o;

  modport slave (
    input  exception_i,
    input  mret_i,
    input  irq_req_i,
    input  mie_i,
    output irq_o,
    output irq_cause_o,
    output irq_ret_o,
    output busy_o
  );

  modport master (
    output exception_i,
    output mret_i,
    output irq_req_i,
    output mie_i,
    input  irq_o,
    input  irq_cause_o,
    input  irq_ret_o,
    input  busy_o
  );
endinterface

// File: rtl/irq_controller_vec.sv
// Vectored multi-channel interrupt controller with handler tracking.
// Optional macro IRQ_ROUND_ROBIN_EN: round-robin instead of fixed priority.
module irq_controller_vec #(
  parameter int          IRQ_NUM        = 16,
  parameter logic [31:0] IRQ_CAUSE_BASE = 32'h8000_0010,
  parameter logic [31:0] EDGE_MASK      = 32'h0
) (
  input  logic               clk_i,
  input  logic               rst_i,
  irq_controller_vec_if.slave bus
);

  localparam int IW = (IRQ_NUM > 1) ? $clog2(IRQ_NUM) : 1;

  typedef logic [IRQ_NUM-1:0] vec_t;

  localparam vec_t EDGE = EDGE_MASK[IRQ_NUM-1:0];

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    EXC     = 2'b01,
    IRQ     = 2'b10,
    IRQ_EXC = 2'b11
  } state_t;

  state_t        state_q;
  state_t        state_d;
  vec_t          pend;
  vec_t          req_q;
  vec_t          cand;
  vec_t          take_mask;
  vec_t          ret;
  logic [IW-1:0] sel;
  logic [IW-1:0] cur_id;
  logic          irq_h;
  logic          exc_h;
  logic          irq;
  logic          pulse;

  function automatic logic [IW-1:0] lowest(input vec_t v);
    lowest = '0;
    for (int i = IRQ_NUM - 1; i >= 0; i--)
      if (v[i]) lowest = IW'(i);
  endfunction

  assign irq_h = state_q[1];
  assign exc_h = state_q[0];
  assign cand  = pend & bus.mie_i;
  assign irq   = (|cand) & ~irq_h & ~exc_h
               & ~bus.exception_i;

`ifdef IRQ_ROUND_ROBIN_EN
  logic [IW-1:0] rr_ptr;
  logic [2*IRQ_NUM-1:0] dbl;
  logic [IW:0] sum;

  // first candidate at or above rr_ptr, wrapping at IRQ_NUM
  always_comb begin
    dbl = {cand, cand} >> rr_ptr;
    sum = {1'b0, rr_ptr}
        + {1'b0, lowest(dbl[IRQ_NUM-1:0])};
    if (sum >= (IW+1)'(IRQ_NUM))
      sum = sum - (IW+1)'(IRQ_NUM);
    sel = sum[IW-1:0];
  end

  // pointer moves past each accepted channel
  always_ff @(posedge clk_i) begin
    if (rst_i)
      rr_ptr <= '0;
    else if (irq)
      rr_ptr <= (sel == IW'(IRQ_NUM - 1))
              ? '0 : sel + 1'b1;
  end
`else
  // fixed priority: channel 0 highest
  always_comb sel = lowest(cand);
`endif

  assign take_mask = irq ? (vec_t'(1) << sel) : '0;

  // request sampling; edge channels latch until taken
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      req_q <= '0;
      pend  <= '0;
    end else begin
      req_q <= bus.irq_req_i;
      pend  <= (EDGE & ((pend & ~take_mask)
                | (bus.irq_req_i & ~req_q)))
             | (~EDGE & bus.irq_req_i);
    end
  end

  // handler state and active channel id
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cur_id  <= '0;
    end else begin
      state_q <= state_d;
      if (irq) cur_id <= sel;
    end
  end

  // exception always sets exc_h; mret unwinds exc first
  always_comb begin
    state_d = state_q;
    pulse   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.exception_i) state_d = EXC;
        else if (irq)        state_d = IRQ;
      end
      IRQ: begin
        pulse = bus.mret_i;
        if (bus.exception_i)
          state_d = bus.mret_i ? EXC : IRQ_EXC;
        else if (bus.mret_i)
          state_d = IDLE;
      end
      EXC: begin
        if (!bus.exception_i && bus.mret_i)
          state_d = IDLE;
      end
      IRQ_EXC: begin
        if (!bus.exception_i && bus.mret_i)
          state_d = IRQ;
      end
      default: state_d = IDLE;
    endcase
  end

  assign ret = pulse ? (vec_t'(1) << cur_id) : '0;

  assign bus.irq_o       = irq;
  assign bus.irq_cause_o = IRQ_CAUSE_BASE
                         + 32'(irq ? sel : cur_id);
  assign bus.irq_ret_o   = ret;
  assign bus.busy_o      = irq_h;

endmodule

// File: tb/tb_irq_controller_vec.sv
// Self-checking bench for irq_controller_vec.
// Two instances: all-level channels, and EDGE_MASK = 32'h00F0.
module tb_irq_controller_vec;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  irq_controller_vec_if #(.IRQ_NUM(16)) a_if ();
  irq_controller_vec_if #(.IRQ_NUM(16)) e_if ();

  irq_controller_vec #(
    .IRQ_NUM(16),
    .IRQ_CAUSE_BASE(32'h8000_0010),
    .EDGE_MASK(32'h0)
  ) dut_a (
    .clk_i(clk),
    .rst_i(rst),
    .bus(a_if.slave)
  );

  irq_controller_vec #(
    .IRQ_NUM(16),
    .IRQ_CAUSE_BASE(32'h8000_0010),
    .EDGE_MASK(32'h0000_00F0)
  ) dut_e (
    .clk_i(clk),
    .rst_i(rst),
    .bus(e_if.slave)
  );

  int errors = 0;
  int checks = 0;
  logic [31:0] cause_q[$];
  logic [15:0] ret_q[$];

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_irq(input bit use_e,
                          input int budget,
                          output bit seen,
                          output logic [31:0] cause);
    seen  = 1'b0;
    cause = '0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (use_e ? e_if.irq_o : a_if.irq_o) begin
        seen  = 1'b1;
        cause = use_e ? e_if.irq_cause_o
                      : a_if.irq_cause_o;
      end
    end
  endtask

  task automatic do_reset();
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (a_if.irq_o !== 1'b0 || a_if.busy_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags irq=%b busy=%b want 0 0",
               a_if.irq_o, a_if.busy_o);
    end
    checks++;
    if (a_if.irq_ret_o !== 16'h0) begin
      errors++;
      $display("FAIL reset_ret got %h want 0000",
               a_if.irq_ret_o);
    end
    checks++;
    if (a_if.irq_cause_o !== 32'h8000_0010) begin
      errors++;
      $display("FAIL reset_cause got %h want 80000010",
               a_if.irq_cause_o);
    end
  endtask

  task automatic test_basic();
    bit seen;
    logic [31:0] c;
    logic [31:0] ex;
    cyc();
    a_if.irq_req_i = 16'h0008;
    cause_q.push_back(32'h8000_0013);
    @(negedge clk);
    checks++;
    if (a_if.irq_o !== 1'b0) begin
      errors++;
      $display("FAIL basic_latency irq=%b want 0",
               a_if.irq_o);
    end
    wait_irq(1'b0, 4, seen, c);
    ex = cause_q.pop_front();
    checks++;
    if (!seen || c !== ex) begin
      errors++;
      $display("FAIL basic_take seen=%b cause=%h want %h",
               seen, c, ex);
    end
    cyc();
    a_if.irq_req_i = '0;
    @(negedge clk);
    checks++;
    if (a_if.busy_o !== 1'b1 || a_if.irq_o !== 1'b0) begin
      errors++;
      $display("FAIL basic_busy busy=%b irq=%b want 1 0",
               a_if.busy_o, a_if.irq_o);
    end
    cyc();
    a_if.mret_i = 1'b1;
    ret_q.push_back(16'h0008);
    @(negedge clk);
    checks++;
    if (a_if.irq_ret_o !== ret_q[0]) begin
      errors++;
      $display("FAIL basic_ret got %h want %h",
               a_if.irq_ret_o, ret_q[0]);
    end
    void'(ret_q.pop_front());
    cyc();
    a_if.mret_i = 1'b0;
    @(negedge clk);
    checks++;
    if (a_if.irq_ret_o !== 16'h0 || a_if.busy_o !== 1'b0) begin
      errors++;
      $display("FAIL basic_release ret=%h busy=%b want 0 0",
               a_if.irq_ret_o, a_if.busy_o);
    end
  endtask

  task automatic test_priority();
    bit seen;
    logic [31:0] c;
    logic [31:0] ex;
    logic [15:0] er;
    cyc();
    a_if.irq_req_i = 16'h0810;
    cause_q.push_back(32'h8000_0014);
    cause_q.push_back(32'h8000_001B);
    wait_irq(1'b0, 4, seen, c);
    ex = cause_q.pop_front();
    checks++;
    if (!seen || c !== ex) begin
      errors++;
      $display("FAIL prio_first seen=%b cause=%h want %h",
               seen, c, ex);
    end
    cyc();
    a_if.irq_req_i = 16'h0800;
    cyc();
    a_if.mret_i = 1'b1;
    ret_q.push_back(16'h0010);
    @(negedge clk);
    er = ret_q.pop_front();
    checks++;
    if (a_if.irq_ret_o !== er) begin
      errors++;
      $display("FAIL prio_ret got %h want %h",
               a_if.irq_ret_o, er);
    end
    cyc();
    a_if.mret_i = 1'b0;
    @(negedge clk);
    ex = cause_q.pop_front();
    checks++;
    if (a_if.irq_o !== 1'b1 || a_if.irq_cause_o !== ex) begin
      errors++;
      $display("FAIL prio_second irq=%b cause=%h want 1 %h",
               a_if.irq_o, a_if.irq_cause_o, ex);
    end
    cyc();
    a_if.irq_req_i = '0;
    cyc();
    a_if.mret_i = 1'b1;
    ret_q.push_back(16'h0800);
    @(negedge clk);
    er = ret_q.pop_front();
    checks++;
    if (a_if.irq_ret_o !== er) begin
      errors++;
      $display("FAIL prio_ret2 got %h want %h",
               a_if.irq_ret_o, er);
    end
    cyc();
    a_if.mret_i = 1'b0;
  endtask

  task automatic test_edge_latch();
    bit seen;
    logic [31:0] c;
    logic [31:0] ex;
    logic [15:0] er;
    int bad;
    e_if.mie_i = 16'hFFDF;
    cyc();
    e_if.irq_req_i = 16'h0020;
    cyc();
    e_if.irq_req_i = '0;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (e_if.irq_o !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL edge_masked irq high %0d cycles want 0",
               bad);
    end
    cyc();
    e_if.mie_i = 16'hFFFF;
    cause_q.push_back(32'h8000_0015);
    wait_irq(1'b1, 3, seen, c);
    ex = cause_q.pop_front();
    checks++;
    if (!seen || c !== ex) begin
      errors++;
      $display("FAIL edge_take seen=%b cause=%h want %h",
               seen, c, ex);
    end
    cyc();
    e_if.mret_i = 1'b1;
    ret_q.push_back(16'h0020);
    @(negedge clk);
    er = ret_q.pop_front();
    checks++;
    if (e_if.irq_ret_o !== er) begin
      errors++;
      $display("FAIL edge_ret got %h want %h",
               e_if.irq_ret_o, er);
    end
    cyc();
    e_if.mret_i = 1'b0;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (e_if.irq_o !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL edge_once irq high %0d cycles want 0",
               bad);
    end
  endtask

  task automatic test_exception();
    logic [31:0] ex;
    logic [15:0] er;
    cyc();
    a_if.irq_req_i = 16'h0004;
    cyc();
    a_if.exception_i = 1'b1;
    @(negedge clk);
    checks++;
    if (a_if.irq_o !== 1'b0) begin
      errors++;
      $display("FAIL exc_wins irq=%b want 0", a_if.irq_o);
    end
    cyc();
    a_if.exception_i = 1'b0;
    @(negedge clk);
    checks++;
    if (a_if.irq_o !== 1'b0 || a_if.busy_o !== 1'b0) begin
      errors++;
      $display("FAIL exc_hold irq=%b busy=%b want 0 0",
               a_if.irq_o, a_if.busy_o);
    end
    cyc();
    a_if.mret_i = 1'b1;
    @(negedge clk);
    checks++;
    if (a_if.irq_ret_o !== 16'h0) begin
      errors++;
      $display("FAIL exc_mret ret=%h want 0000",
               a_if.irq_ret_o);
    end
    cyc();
    a_if.mret_i = 1'b0;
    cause_q.push_back(32'h8000_0012);
    @(negedge clk);
    ex = cause_q.pop_front();
    checks++;
    if (a_if.irq_o !== 1'b1 || a_if.irq_cause_o !== ex) begin
      errors++;
      $display("FAIL exc_take irq=%b cause=%h want 1 %h",
               a_if.irq_o, a_if.irq_cause_o, ex);
    end
    cyc();
    a_if.irq_req_i = '0;
    cyc();
    a_if.exception_i = 1'b1;
    cyc();
    a_if.exception_i = 1'b0;
    cyc();
    a_if.mret_i = 1'b1;
    @(negedge clk);
    checks++;
    if (a_if.irq_ret_o !== 16'h0 || a_if.busy_o !== 1'b1) begin
      errors++;
      $display("FAIL nest_mret1 ret=%h busy=%b want 0000 1",
               a_if.irq_ret_o, a_if.busy_o);
    end
    cyc();
    a_if.mret_i = 1'b0;
    @(negedge clk);
    checks++;
    if (a_if.busy_o !== 1'b1) begin
      errors++;
      $display("FAIL nest_busy busy=%b want 1", a_if.busy_o);
    end
    cyc();
    a_if.mret_i = 1'b1;
    ret_q.push_back(16'h0004);
    @(negedge clk);
    er = ret_q.pop_front();
    checks++;
    if (a_if.irq_ret_o !== er) begin
      errors++;
      $display("FAIL nest_mret2 ret=%h want %h",
               a_if.irq_ret_o, er);
    end
    cyc();
    a_if.mret_i = 1'b0;
    @(negedge clk);
    checks++;
    if (a_if.busy_o !== 1'b0) begin
      errors++;
      $display("FAIL nest_done busy=%b want 0", a_if.busy_o);
    end
  endtask

  task automatic test_masking();
    bit seen;
    logic [31:0] c;
    logic [31:0] ex;
    int bad;
    cyc();
    a_if.irq_req_i = 16'h0200;
    cause_q.push_back(32'h8000_0019);
    wait_irq(1'b0, 4, seen, c);
    ex = cause_q.pop_front();
    checks++;
    if (!seen || c !== ex) begin
      errors++;
      $display("FAIL rst_take seen=%b cause=%h want %h",
               seen, c, ex);
    end
    cyc();
    a_if.irq_req_i = '0;
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    a_if.mret_i = 1'b1;
    @(negedge clk);
    checks++;
    if (a_if.irq_ret_o !== 16'h0 || a_if.busy_o !== 1'b0) begin
      errors++;
      $display("FAIL rst_abandon ret=%h busy=%b want 0000 0",
               a_if.irq_ret_o, a_if.busy_o);
    end
    cyc();
    a_if.mret_i = 1'b0;
    a_if.mie_i = 16'hFF7F;
    a_if.irq_req_i = 16'h0080;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      bad = (a_if.irq_o !== 1'b0
          || a_if.irq_cause_o !== 32'h8000_0010) ? 1 : 0;
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL mask_c%0d irq=%b cause=%h want 0 80000010",
                 i, a_if.irq_o, a_if.irq_cause_o);
      end
      cyc();
    end
    a_if.irq_req_i = '0;
    cyc();
    a_if.mie_i = 16'hFFFF;
  endtask

  task automatic test_arbitration();
    bit seen;
    logic [31:0] c;
    logic [31:0] ex;
    logic [15:0] er;
    do_reset();
`ifdef IRQ_ROUND_ROBIN_EN
    for (int r = 0; r < 4; r++) begin
      cause_q.push_back(r[0] ? 32'h8000_0012
                             : 32'h8000_0011);
      ret_q.push_back(r[0] ? 16'h0004 : 16'h0002);
    end
`else
    for (int r = 0; r < 4; r++) begin
      cause_q.push_back(32'h8000_0011);
      ret_q.push_back(16'h0002);
    end
`endif
    a_if.irq_req_i = 16'h0006;
    for (int r = 0; r < 4; r++) begin
      wait_irq(1'b0, 6, seen, c);
      ex = cause_q.pop_front();
      checks++;
      if (!seen || c !== ex) begin
        errors++;
        $display("FAIL arb_take%0d seen=%b cause=%h want %h",
                 r, seen, c, ex);
      end
      cyc();
      cyc();
      a_if.mret_i = 1'b1;
      @(negedge clk);
      er = ret_q.pop_front();
      checks++;
      if (a_if.irq_ret_o !== er) begin
        errors++;
        $display("FAIL arb_ret%0d got %h want %h",
                 r, a_if.irq_ret_o, er);
      end
      cyc();
      a_if.mret_i = 1'b0;
    end
    a_if.irq_req_i = '0;
  endtask

  initial begin
    a_if.exception_i = 1'b0;
    a_if.mret_i      = 1'b0;
    a_if.irq_req_i   = '0;
    a_if.mie_i       = 16'hFFFF;
    e_if.exception_i = 1'b0;
    e_if.mret_i      = 1'b0;
    e_if.irq_req_i   = '0;
    e_if.mie_i       = 16'hFFFF;
    test_reset();
    test_basic();
    test_priority();
    test_edge_latch();
    test_exception();
    test_masking();
    test_arbitration();
    checks++;
    if (cause_q.size() != 0 || ret_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain causes=%0d rets=%0d want 0 0",
               cause_q.size(), ret_q.size());
    end
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
